// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch-side initiator for a combinational instruction memory. Holds the PC,
//   drives the word address, buffers returned words in a small FIFO and hands
//   {pc, instr} to decode over a valid/ready handshake. Handles redirects,
//   flushing and misaligned-target faults.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   imem_addr      byte address to instruction memory (equals internal pc)
//   imem_instr     instruction word returned combinationally for imem_addr
//   redirect_valid one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc    redirect target byte address
//   out_valid      FIFO head holds a valid {pc, instr}
//   out_ready      decode accepts head this cycle when out_valid=1
//   out_pc         PC of head entry
//   out_instr      instruction of head entry
//   fetch_fault    sticky: last redirect target was misaligned
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    rst_sync_q;
  logic          run;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   last_pc_q, last_pc_d;
  logic [31:0]   last_instr_q, last_instr_d;
  logic          fault_q, fault_d;
  logic          pop, push, misaligned;

  // Reset asserts asynchronously but releases through two flops, so the
  // core only starts fetching two edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign run        = ~rst_sync_q[1];
  assign out_valid  = (count_q != '0);
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign pop        = out_valid & out_ready;
  assign push       = run & (state_q == ST_FETCH) & ~redirect_valid &
                      ((count_q < DEPTH_C) | pop);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    fault_d      = fault_q;

    // A head popped in the same cycle as a redirect still counts as consumed.
    if (pop) begin
      last_pc_d    = pc_mem_q[rd_ptr_q];
      last_instr_d = instr_mem_q[rd_ptr_q];
    end

    if (run && redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      fault_d  = misaligned;
      state_d  = misaligned ? ST_FAULT : ST_FETCH;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
      fault_q      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
      fault_q      <= fault_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= pc_q;
        instr_mem_q[wr_ptr_q] <= imem_instr;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;
  // With the FIFO empty the outputs show the most recently consumed entry.
  assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q]    : last_pc_q;
  assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : last_instr_q;

endmodule
